// File: rtl/iter_alu.sv
// Handshaked RV32I ALU with iterative M-extension multiply/divide.
// Define ITER_ALU_MDU_EN to build the MUL/DIV datapath; otherwise every M op reports illegal.
module iter_alu #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] d1,
  input  logic [XLEN-1:0] d2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            out_illegal
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic            base_ill;

  assign accept      = in_valid & in_ready;
  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign result      = result_q;
  assign out_illegal = illegal_q;
  assign shamt       = d2[SHW-1:0];

  always_comb begin
    base_res = '0;
    base_ill = 1'b0;
    case (op[3:0])
      4'b0000: base_res = d1 + d2;
      4'b0001: base_res = d1 << shamt;
      4'b0010: base_res = {{(XLEN-1){1'b0}}, $signed(d1) < $signed(d2)};
      4'b0011: base_res = {{(XLEN-1){1'b0}}, d1 < d2};
      4'b0100: base_res = d1 ^ d2;
      4'b0101: base_res = d1 >> shamt;
      4'b0110: base_res = d1 | d2;
      4'b0111: base_res = d1 & d2;
      4'b1000: base_res = d1 - d2;
      4'b1101: base_res = $unsigned($signed(d1) >>> shamt);
      default: base_ill = 1'b1;
    endcase
  end

`ifdef ITER_ALU_MDU_EN
  // acc holds {hi, lo}: {partial product, multiplier} or {remainder, quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic [XLEN-1:0]   dsr_q, dsr_d, mag1, mag2, quo, rem, fin_res;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic              sgn1, sgn2, s1, s2, div_zero, div_ovf;
  logic [XLEN:0]     mul_sum, div_rem, div_diff;

  always_comb begin
    sgn1     = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    sgn2     = op[2] ? ~op[0] : ~op[1];
    s1       = sgn1 & d1[XLEN-1];
    s2       = sgn2 & d2[XLEN-1];
    mag1     = s1 ? -d1 : d1;
    mag2     = s2 ? -d2 : d2;
    div_zero = (d2 == '0);
    div_ovf  = ~op[0] & (d1 == {1'b1, {(XLEN-1){1'b0}}}) & (d2 == '1);

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dsr_q} : '0);
    div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_rem - {1'b0, dsr_q};
    if (state_q == StMul) begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    prod = (s1_q ^ s2_q) ? -acc_step : acc_step;
    quo  = acc_step[XLEN-1:0];
    rem  = acc_step[2*XLEN-1:XLEN];
    if (state_q == StMul) begin
      fin_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (f3_q[1]) begin
      fin_res = s1_q ? -rem : rem;
    end else begin
      fin_res = (s1_q ^ s2_q) ? -quo : quo;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef ITER_ALU_MDU_EN
    acc_d = acc_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    f3_d  = f3_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StDone;
          illegal_d = 1'b0;
          if (!op[4]) begin
            result_d  = base_res;
            illegal_d = base_ill;
          end else begin
`ifdef ITER_ALU_MDU_EN
            f3_d = op[2:0];
            s1_d = s1;
            s2_d = s2;
            cnt_d = '0;
            if (!op[2]) begin
              state_d = StMul;
              acc_d   = {{XLEN{1'b0}}, mag2};
              dsr_d   = mag1;
            end else if (div_zero) begin
              result_d = op[1] ? d1 : '1;
            end else if (div_ovf) begin
              result_d = op[1] ? '0 : d1;
            end else begin
              state_d = StDiv;
              acc_d   = {{XLEN{1'b0}}, mag1};
              dsr_d   = mag2;
            end
`else
            result_d  = '0;
            illegal_d = 1'b1;
`endif
          end
        end
      end
`ifdef ITER_ALU_MDU_EN
      StMul, StDiv: begin
        acc_d = acc_step;
        cnt_d = cnt_q + SHW'(1);
        // Last iteration folds the sign fix straight into the result register.
        if (cnt_q == SHW'(XLEN - 1)) begin
          state_d  = StDone;
          result_d = fin_res;
        end
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef ITER_ALU_MDU_EN
      acc_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      f3_q  <= '0;
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifdef ITER_ALU_MDU_EN
      acc_q <= acc_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
      f3_q  <= f3_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
`endif
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Randomised self-checking bench for iter_alu against a plain-arithmetic reference model.
// Follows the ITER_ALU_MDU_EN setting of the build for the M-op expectations.
module tb_iter_alu;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] MinNeg = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      op = '0;
  logic [XLEN-1:0] d1 = '0;
  logic [XLEN-1:0] d2 = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            out_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  iter_alu #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .d1         (d1),
    .d2         (d2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit arithmetic straight from the ISA definitions.
  function automatic void model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    longint          sa, sb, ub_s;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              sh;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    ub_s = {32'b0, b};
    sh   = int'(b[4:0]);
    r    = '0;
    ill  = 1'b0;
    lat  = 1;
    if (!o[4]) begin
      case (o[3:0])
        4'd0:    r = a + b;
        4'd1:    r = a << sh;
        4'd2:    r = {31'b0, sa < sb};
        4'd3:    r = {31'b0, a < b};
        4'd4:    r = a ^ b;
        4'd5:    r = a >> sh;
        4'd6:    r = a | b;
        4'd7:    r = a & b;
        4'd8:    r = a - b;
        4'd13: begin p = sa >>> sh; r = p[31:0]; end
        default: ill = 1'b1;
      endcase
    end else begin
`ifdef ITER_ALU_MDU_EN
      lat = XLEN + 1;
      case (o[2:0])
        3'd0: begin p = sa * sb;   r = p[31:0];  end
        3'd1: begin p = sa * sb;   r = p[63:32]; end
        3'd2: begin p = sa * ub_s; r = p[63:32]; end
        3'd3: begin p = ua * ub;   r = p[63:32]; end
        3'd4: begin
          if (b == 0) begin r = '1; lat = 1; end
          else if (a == MinNeg && b == '1) begin r = a; lat = 1; end
          else begin p = sa / sb; r = p[31:0]; end
        end
        3'd5: begin
          if (b == 0) begin r = '1; lat = 1; end
          else begin p = ua / ub; r = p[31:0]; end
        end
        3'd6: begin
          if (b == 0) begin r = a; lat = 1; end
          else if (a == MinNeg && b == '1) begin r = '0; lat = 1; end
          else begin p = sa % sb; r = p[31:0]; end
        end
        default: begin
          if (b == 0) begin r = a; lat = 1; end
          else begin p = ua % ub; r = p[31:0]; end
        end
      endcase
`else
      ill = 1'b1;
`endif
    end
  endfunction

  task automatic do_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int stall);
    logic [31:0] er, held;
    logic        ei, held_ill, bad_busy, bad_hold;
    int          el, n;
    model(o, a, b, er, ei, el);
    @(negedge clk);
    check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op = o;
    d1 = a;
    d2 = b;
    @(negedge clk);
    // Scramble inputs after accept: the DUT must have latched them.
    in_valid = 1'b0;
    op = 5'($urandom);
    d1 = $urandom;
    d2 = $urandom;
    n = 1;
    bad_busy = 1'b0;
    while (!out_valid && n < 200) begin
      if (in_ready) bad_busy = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, n, el);
    check({tag, ".busy_ready"}, {31'b0, bad_busy}, 32'd0);
    check({tag, ".result"}, result, er);
    check({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ei});
    held = result;
    held_ill = out_illegal;
    bad_hold = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== held || out_illegal !== held_ill) bad_hold = 1'b1;
    end
    if (stall > 0) check({tag, ".hold"}, {31'b0, bad_hold}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".drain"}, {30'b0, out_valid, in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return MinNeg;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset.flags", {30'b0, out_valid, in_ready}, 32'd1);
    check("reset.result", result, 32'h0);
    check("reset.illegal", {31'b0, out_illegal}, 32'd0);

    do_op("add_ovf", 5'b00000, 32'h7FFF_FFFF, 32'h1, 0);
    do_op("sra", 5'b01101, MinNeg, 32'h24, 0);
    do_op("sub", 5'b01000, 32'h5, 32'h9, 1);
    do_op("slt", 5'b00010, 32'hFFFF_FFFF, 32'h1, 0);
    do_op("sltu", 5'b00011, 32'hFFFF_FFFF, 32'h1, 0);
    do_op("illegal", 5'b01010, 32'h1234, 32'h5678, 2);
    do_op("mulh", 5'b10001, MinNeg, MinNeg, 0);
    do_op("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("mul", 5'b10000, 32'd7, 32'hFFFF_FFFD, 0);
    do_op("mul34", 5'b10000, 32'd3, 32'd4, 0);
    do_op("div", 5'b10100, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("rem", 5'b10110, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("divu0", 5'b10101, 32'd5, 32'd0, 0);
    do_op("div_ovf", 5'b10100, MinNeg, 32'hFFFF_FFFF, 0);
    do_op("rem_ovf", 5'b10110, MinNeg, 32'hFFFF_FFFF, 0);
    do_op("divu_bp", 5'b10101, 32'd100, 32'd7, 10);

    // Reset mid-operation must drop the pending result.
    @(negedge clk);
    in_valid = 1'b1;
    op = 5'b10101;
    d1 = 32'd100;
    d2 = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.flags", {30'b0, out_valid, in_ready}, 32'd1);
    check("abort.result", result, 32'h0);
    do_op("post_abort", 5'b00000, 32'd2, 32'd3, 0);

    for (int i = 0; i < 60; i++) begin
      do_op($sformatf("rnd%0d", i), 5'($urandom), pick(), pick(), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, handshaked successor to the single-cycle RV32I ALU.
- Executes the base integer ops with one registered cycle of latency.
- Adds RV M-extension multiply/divide as iterative multi-cycle operations.
- Sits in the execute stage; stalls the pipeline through valid/ready when busy.

Parameters:
XLEN, 32, operand/result width; power of two, 8..64.
SHW, $clog2(XLEN), shift-amount width taken from d2 LSBs (derived, not overridden).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept request
op  in  5  op[4]=0 base op (0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA); op[4]=1 M op, op[2:0]=funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
d1  in  XLEN  operand 1 (rs1)
d2  in  XLEN  operand 2 (rs2/imm)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  XLEN  operation result
out_illegal  out  1  op was undefined; result forced 0

Behaviour:
- Reset: state IDLE, out_valid=0, result=0, out_illegal=0, in_ready=1; all iteration registers cleared. Reset mid-operation aborts; the result is discarded.
- in_ready=1 only in IDLE. Accept = in_valid & in_ready; op/d1/d2 are latched on accept and then ignored.
- States: IDLE, MUL, DIV, DONE.
- IDLE -> DONE on accept of a base op, undefined op or division fast path. Result is registered; out_valid=1 the next cycle (latency 1).
- IDLE -> MUL on MUL*. Radix-2 shift-add over 2*XLEN-bit product of magnitudes, XLEN iterations. Sign fixed on exit. Then DONE. Latency XLEN+1 cycles from accept.
- IDLE -> DIV on DIV/DIVU/REM/REMU with nonzero divisor and no overflow. Restoring divide on magnitudes, XLEN iterations. Quotient sign = sign(d1)^sign(d2); remainder sign = sign(d1). Then DONE. Latency XLEN+1.
- DONE: out_valid=1; result/out_illegal held stable until out_ready=1, then -> IDLE. in_ready rises the cycle after the handshake; no back-to-back accept in DONE.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - Shifts use d2[SHW-1:0]; SRA is arithmetic, SRL is logical.
  - SLT is signed, SLTU unsigned; result is 1 or 0 zero-extended.
- Products: MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits, with signed×signed, signed×unsigned (d1 signed) and unsigned×unsigned operands respectively.
- Divide by zero (fast path): DIV/DIVU quotient = all ones; REM/REMU = d1.
- Signed overflow (fast path, DIV/REM with d1 = most-negative and d2 = -1): quotient = d1; remainder = 0.
- Undefined base codes (1001-1100, 1110, 1111): result=0, out_illegal=1, latency 1. out_illegal=0 for every defined op.
- out_valid never asserts without a preceding accept. There is exactly one result per accept.

Optional Feature:
- Macro ITER_ALU_MDU_EN.
- Defined: M ops behave as above.
- Undefined: MUL/DIV states and datapath are not built. Every op[4]=1 request is treated as undefined: result=0, out_illegal=1, latency 1. Base-op behaviour and latency are unchanged.

Test Plan:
- Reset then ADD d1=0x7FFFFFFF, d2=1 -> one cycle later out_valid=1, result=0x80000000, out_illegal=0; SRA d1=0x80000000, d2=0x24 -> 0xF8000000 (shift 4).
- MULH d1=0x80000000, d2=0x80000000 -> result 0x40000000 after 33 cycles; MULHSU d1=0xFFFFFFFF, d2=0xFFFFFFFF -> 0xFFFFFFFF; MUL 7×-3 -> 0xFFFFFFEB; in_ready=0 throughout the iteration.
- DIV d1=-7, d2=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU d1=5, d2=0 -> 0xFFFFFFFF at latency 1; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- Backpressure: DIVU 100/7 with out_ready=0 for 10 cycles after out_valid -> result 14 stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
- Assert rst during cycle 10 of DIVU -> next cycle out_valid=0, in_ready=1; following ADD 2+3 -> 5 with no stale result.
- op=5'b01010 -> result=0, out_illegal=1; with ITER_ALU_MDU_EN undefined, MUL 3×4 -> result=0, out_illegal=1, latency 1.
